snake_line_renderer: RTL and testbench



---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_seg_hit.sv | 38 +++
 rtl/snake_line_renderer.sv | 171 +++++++++++++++++
 tb/tb_snake_line_renderer.sv | 581 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg
// Shared constants, FSM state encoding and a segment-slice helper for the
// snake line renderer.
//   SEG_BITS  width of one packed X or Y coordinate
//   MAX_SEG   number of segment slots on the position buses
//   H_ACTIVE  visible pixels per line (line mask width)
//   V_ACTIVE  visible lines per frame
//   SEG_SIZE  side length of the square drawn for each segment
package snake_pkg;

  localparam int SEG_BITS = 10;
  localparam int MAX_SEG  = 100;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SEG_SIZE = 10;
  localparam int BUS_W    = SEG_BITS * MAX_SEG;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Extract coordinate slot idx from a packed position bus.
  function automatic logic [SEG_BITS-1:0] seg_slice(input logic [BUS_W-1:0] bus,
                                                    input logic [6:0]       idx);
    return bus[int'(idx) * SEG_BITS +: SEG_BITS];
  endfunction

endpackage

// File: rtl/snake_seg_hit.sv
// snake_seg_hit
// Combinational hit test of one snake segment against the scanline being
// built, plus the horizontal span that segment covers on that line.
//   sx, sy  segment top-left corner
//   ty      Y of the line being built
//   hit     segment overlaps line ty and starts inside the visible area
//   span    H_ACTIVE-wide mask with SEG_SIZE ones starting at sx, clipped at
//           the right edge (no wrap); all zero when there is no hit
module snake_seg_hit
  import snake_pkg::*;
(
  input  logic [SEG_BITS-1:0] sx,
  input  logic [SEG_BITS-1:0] sy,
  input  logic [SEG_BITS-1:0] ty,
  output logic                hit,
  output logic [H_ACTIVE-1:0] span
);

  localparam logic [H_ACTIVE-1:0] SPAN_BASE =
    {{(H_ACTIVE-SEG_SIZE){1'b0}}, {SEG_SIZE{1'b1}}};

  logic [SEG_BITS:0] sx_w;
  logic [SEG_BITS:0] sy_w;
  logic [SEG_BITS:0] ty_w;

  // One extra bit keeps sy+SEG_SIZE from wrapping near the top of the range;
  // bits shifted past the mask width simply fall off, so there is no wrap.
  always_comb begin
    sx_w = {1'b0, sx};
    sy_w = {1'b0, sy};
    ty_w = {1'b0, ty};
    hit  = (sy_w <= ty_w) &&
           (ty_w < (sy_w + 11'(SEG_SIZE))) &&
           (sx_w < 11'(H_ACTIVE));
    span = hit ? (SPAN_BASE << sx) : '0;
  end

endmodule

// File: rtl/snake_line_renderer.sv
// snake_line_renderer
// Builds a one-line snake mask during horizontal blanking (one segment per
// clock) and serves it pixel by pixel during active video.
//   clock, reset        pixel clock, synchronous active-high reset
//   pos_x, pos_y        packed segment positions, head in slot 0
//   length              body segments behind the head
//   frame_start         pulse: take a new position snapshot
//   line_req, line_y    pulse + Y of the next line to build
//   h_count, video_on   current pixel X and active-video qualifier
//   snake_pixel         pixel covered by any segment (registered)
//   head_pixel          pixel covered by the head (registered)
//   busy                scan or commit in progress
//   overrun             sticky: a line was not committed in time
module snake_line_renderer
  import snake_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [BUS_W-1:0]    pos_x,
  input  logic [BUS_W-1:0]    pos_y,
  input  logic [SEG_BITS-1:0] length,
  input  logic                frame_start,
  input  logic                line_req,
  input  logic [SEG_BITS-1:0] line_y,
  input  logic [SEG_BITS-1:0] h_count,
  input  logic                video_on,
  output logic                snake_pixel,
  output logic                head_pixel,
  output logic                busy,
  output logic                overrun
);

  state_t              state;
  logic [BUS_W-1:0]    snap_x;
  logic [BUS_W-1:0]    snap_y;
  logic [SEG_BITS-1:0] snap_len;
  logic                snap_pending;
  logic [SEG_BITS-1:0] ty;
  logic [6:0]          idx;
  logic [H_ACTIVE-1:0] build_mask;
  logic [H_ACTIVE-1:0] disp_mask;
  logic                bh_valid;
  logic [SEG_BITS:0]   bh_lo;
  logic [SEG_BITS:0]   bh_hi;
  logic                head_valid;
  logic [SEG_BITS:0]   hx_lo;
  logic [SEG_BITS:0]   hx_hi;

  logic [SEG_BITS:0]   len_p1;
  logic [6:0]          nseg;
  logic [SEG_BITS-1:0] cur_x;
  logic [SEG_BITS-1:0] cur_y;
  logic                seg_hit;
  logic [H_ACTIVE-1:0] seg_span;

  // Segment count is clamped to the bus capacity, so slots past length are
  // never examined.
  always_comb begin
    len_p1 = {1'b0, snap_len} + 11'd1;
    nseg   = (len_p1 > 11'(MAX_SEG)) ? 7'(MAX_SEG) : len_p1[6:0];
    cur_x  = seg_slice(snap_x, idx);
    cur_y  = seg_slice(snap_y, idx);
  end

  snake_seg_hit u_seg_hit (
    .sx   (cur_x),
    .sy   (cur_y),
    .ty   (ty),
    .hit  (seg_hit),
    .span (seg_span)
  );

  // Snapshot, scan FSM and line buffers. A frame_start that arrives while a
  // line is in flight is deferred so the running scan sees stable positions.
  // A new line_req always wins: it restarts the scan and flags an overrun if
  // the previous line had not finished.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      snap_x       <= '0;
      snap_y       <= '0;
      snap_len     <= '0;
      snap_pending <= 1'b0;
      ty           <= '0;
      idx          <= '0;
      build_mask   <= '0;
      disp_mask    <= '0;
      bh_valid     <= 1'b0;
      bh_lo        <= '0;
      bh_hi        <= '0;
      head_valid   <= 1'b0;
      hx_lo        <= '0;
      hx_hi        <= '0;
    end else begin
      if ((state == IDLE) && (frame_start || snap_pending)) begin
        snap_x       <= pos_x;
        snap_y       <= pos_y;
        snap_len     <= length;
        snap_pending <= 1'b0;
      end else if (frame_start) begin
        snap_pending <= 1'b1;
      end

      if (line_req) begin
        state      <= SCAN;
        busy       <= 1'b1;
        ty         <= line_y;
        idx        <= '0;
        build_mask <= '0;
        bh_valid   <= 1'b0;
        bh_lo      <= '0;
        bh_hi      <= '0;
        if (state != IDLE) begin
          overrun <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          SCAN: begin
            if (seg_hit) begin
              build_mask <= build_mask | seg_span;
              if (idx == 7'd0) begin
                bh_valid <= 1'b1;
                bh_lo    <= {1'b0, cur_x};
                bh_hi    <= {1'b0, cur_x} + 11'(SEG_SIZE);
              end
            end
            if (idx == (nseg - 7'd1)) begin
              state <= COMMIT;
            end else begin
              idx <= idx + 7'd1;
            end
          end
          COMMIT: begin
            if (!video_on) begin
              disp_mask  <= build_mask;
              head_valid <= bh_valid;
              hx_lo      <= bh_lo;
              hx_hi      <= bh_hi;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel output stage, one cycle behind h_count / video_on.
  always_ff @(posedge clock) begin
    if (reset) begin
      snake_pixel <= 1'b0;
      head_pixel  <= 1'b0;
    end else begin
      snake_pixel <= video_on && (h_count < 10'(H_ACTIVE)) && disp_mask[h_count];
      head_pixel  <= video_on && head_valid &&
                     ({1'b0, h_count} >= hx_lo) && ({1'b0, h_count} < hx_hi);
    end
  end

endmodule

// File: tb/tb_snake_line_renderer.sv
// tb_snake_line_renderer
// Self-checking bench for snake_line_renderer. A geometric reference model
// (segment squares intersected with a line) predicts every pixel.
module tb_snake_line_renderer;

  logic         clock = 1'b0;
  logic         reset;
  logic [999:0] pos_x;
  logic [999:0] pos_y;
  logic [9:0]   length;
  logic         frame_start;
  logic         line_req;
  logic [9:0]   line_y;
  logic [9:0]   h_count;
  logic         video_on;
  logic         snake_pixel;
  logic         head_pixel;
  logic         busy;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  // Bench-side copy of the position bus.
  int bx[100];
  int by[100];
  int blen;
  // Model of the snapshot used for the next scan.
  int sx_m[100];
  int sy_m[100];
  int slen_m;
  // Model of the line currently on display.
  int dx[100];
  int dy[100];
  int dn;
  int dty;
  bit dvalid;
  bit exp_ovr;

  snake_line_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .length      (length),
    .frame_start (frame_start),
    .line_req    (line_req),
    .line_y      (line_y),
    .h_count     (h_count),
    .video_on    (video_on),
    .snake_pixel (snake_pixel),
    .head_pixel  (head_pixel),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic int nseg_of(int len);
    return (len + 1 > 100) ? 100 : len + 1;
  endfunction

  function automatic bit seg_on_line(int x, int y, int ly);
    return (ly >= y) && (ly < y + 10) && (x < 640);
  endfunction

  function automatic bit exp_snake(int h);
    if (!dvalid || h >= 640) return 1'b0;
    for (int i = 0; i < dn; i++)
      if (seg_on_line(dx[i], dy[i], dty) && h >= dx[i] && h < dx[i] + 10) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_head(int h);
    if (!dvalid || !seg_on_line(dx[0], dy[0], dty)) return 1'b0;
    return (h >= dx[0]) && (h < dx[0] + 10);
  endfunction

  task automatic snap_from_bus();
    for (int i = 0; i < 100; i++) begin
      sx_m[i] = bx[i];
      sy_m[i] = by[i];
    end
    slen_m = blen;
  endtask

  task automatic commit_model(input int ly);
    for (int i = 0; i < 100; i++) begin
      dx[i] = sx_m[i];
      dy[i] = sy_m[i];
    end
    dn     = nseg_of(slen_m);
    dty    = ly;
    dvalid = 1'b1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_bus();
    for (int i = 0; i < 100; i++) begin
      pos_x[i*10 +: 10] = 10'(bx[i]);
      pos_y[i*10 +: 10] = 10'(by[i]);
    end
    length = 10'(blen);
  endtask

  task automatic fill_bus(input int x, input int y);
    for (int i = 0; i < 100; i++) begin
      bx[i] = x;
      by[i] = y;
    end
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_line_req(input int ly);
    line_y   = 10'(ly);
    line_req = 1'b1;
    @(posedge clock); #1;
    line_req = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      @(posedge clock); #1;
    end
  endtask

  task automatic run_line(input int ly, output int cnt);
    pulse_line_req(ly);
    wait_idle(cnt);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if ({snake_pixel, head_pixel, busy, overrun} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b exp=0000", {snake_pixel, head_pixel, busy, overrun});
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h += 7) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_mask h=%0d got=%b exp=00", h, {snake_pixel, head_pixel});
      end
    end
    video_on = 1'b0;
    // Zeroed snapshot means a single head at (0,0) is scanned.
    run_line(5, cnt);
    commit_model(5);
    checks++;
    if (cnt != 2) begin
      failures++;
      $display("[TB] FAIL reset_snap_busy got=%0d exp=2", cnt);
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL reset_snap_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_head_only();
    int cnt;
    fill_bus(200, 120);          // stale body slots that would hit if scanned
    bx[0] = 320; by[0] = 120; blen = 0;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    run_line(125, cnt);
    commit_model(125);
    checks++;
    if (cnt != 2) begin
      failures++;
      $display("[TB] FAIL head_busy got=%0d exp=2", cnt);
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL head_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
    h_count  = 10'd325;
    @(posedge clock); #1;
    checks++;
    if ({snake_pixel, head_pixel} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL head_video_off got=%b exp=00", {snake_pixel, head_pixel});
    end
  endtask

  task automatic test_no_hit();
    int cnt;
    fill_bus(500, 125);          // stale slots beyond length that would hit line 130
    bx[0] = 50;  by[0] = 300;
    bx[1] = 300; by[1] = 120;
    bx[2] = 310; by[2] = 120;
    blen = 2;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    run_line(130, cnt);
    commit_model(130);
    checks++;
    if (cnt != 4) begin
      failures++;
      $display("[TB] FAIL no_hit_busy got=%0d exp=4", cnt);
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL no_hit_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_right_edge();
    int cnt;
    fill_bus(0, 400);
    bx[0] = 100; by[0] = 300;
    bx[1] = 635; by[1] = 115;
    bx[2] = 700; by[2] = 118;    // off-screen X never draws
    blen = 2;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    run_line(120, cnt);
    commit_model(120);
    checks++;
    if (cnt != 4) begin
      failures++;
      $display("[TB] FAIL edge_busy got=%0d exp=4", cnt);
    end
    video_on = 1'b1;
    for (int h = 0; h < 645; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL edge_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_clamp();
    int cnt;
    for (int i = 0; i < 100; i++) begin
      bx[i] = $urandom_range(0, 639);
      by[i] = $urandom_range(200, 215);
    end
    blen = 150;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    run_line(210, cnt);
    commit_model(210);
    checks++;
    if (cnt != 101) begin
      failures++;
      $display("[TB] FAIL clamp_busy got=%0d exp=101", cnt);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clamp_overrun got=%b exp=0", overrun);
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL clamp_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_random_lines();
    int cnt;
    int ly;
    for (int it = 0; it < 4; it++) begin
      ly   = $urandom_range(0, 479);
      blen = $urandom_range(0, 120);
      for (int i = 0; i < 100; i++) begin
        bx[i] = $urandom_range(0, 700);
        by[i] = $urandom_range(0, 479);
        if ($urandom_range(0, 2) == 0) begin
          by[i] = ly - $urandom_range(0, 9);
          if (by[i] < 0) by[i] = 0;
        end
      end
      drive_bus();
      pulse_frame_start();
      snap_from_bus();
      run_line(ly, cnt);
      commit_model(ly);
      checks++;
      if (cnt != nseg_of(slen_m) + 1) begin
        failures++;
        $display("[TB] FAIL random_busy it=%0d got=%0d exp=%0d", it, cnt, nseg_of(slen_m) + 1);
      end
      video_on = 1'b1;
      for (int h = 0; h < 640; h++) begin
        h_count = 10'(h);
        @(posedge clock); #1;
        checks++;
        if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
          failures++;
          $display("[TB] FAIL random_line it=%0d h=%0d got=%b exp=%b", it, h,
                   {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
        end
      end
      video_on = 1'b0;
    end
  endtask

  task automatic test_frame_start_mid_scan();
    int cnt;
    fill_bus(600, 50);
    bx[0] = 100; by[0] = 247;
    bx[5] = 200; by[5] = 241;
    blen = 20;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    pulse_line_req(250);
    repeat (5) @(posedge clock);
    #1;
    fill_bus(20, 50);
    bx[0] = 400; by[0] = 245;
    bx[3] = 450; by[3] = 250;
    blen = 20;
    drive_bus();
    pulse_frame_start();         // arrives during SCAN: deferred
    wait_idle(cnt);
    commit_model(250);           // line built from the old snapshot
    snap_from_bus();             // deferred snapshot picks up the new bus
    checks++;
    if (cnt >= 400) begin
      failures++;
      $display("[TB] FAIL fs_mid_timeout got=%0d exp=<400", cnt);
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL fs_mid_old h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
    run_line(250, cnt);
    commit_model(250);
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL fs_mid_new h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_abort();
    int cnt;
    for (int i = 0; i < 100; i++) begin
      bx[i] = $urandom_range(0, 630);
      by[i] = $urandom_range(300, 330);
    end
    blen = 40;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    pulse_line_req(305);
    repeat (10) @(posedge clock);
    #1;
    run_line(322, cnt);
    commit_model(322);
    exp_ovr = 1'b1;
    checks++;
    if (cnt != 42) begin
      failures++;
      $display("[TB] FAIL abort_busy got=%0d exp=42", cnt);
    end
    checks++;
    if (overrun !== exp_ovr) begin
      failures++;
      $display("[TB] FAIL abort_overrun got=%b exp=%b", overrun, exp_ovr);
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL abort_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    pulse_line_req(310);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b0;
    dvalid  = 1'b0;
    exp_ovr = 1'b0;
    checks++;
    if ({busy, overrun} !== {1'b0, exp_ovr}) begin
      failures++;
      $display("[TB] FAIL rst_mid_status got=%b exp=00", {busy, overrun});
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL rst_mid_mask h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
  endtask

  task automatic test_overrun();
    int cnt;
    fill_bus(0, 470);
    bx[0] = 60;  by[0] = 95;
    bx[2] = 500; by[2] = 92;
    blen = 5;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    run_line(100, cnt);
    commit_model(100);
    for (int i = 0; i < 100; i++) begin
      bx[i] = $urandom_range(0, 639);
      by[i] = $urandom_range(395, 405);
    end
    bx[0] = 30; by[0] = 398;
    blen = 99;
    drive_bus();
    pulse_frame_start();
    snap_from_bus();
    pulse_line_req(400);
    repeat (20) @(posedge clock);
    #1;
    video_on = 1'b1;
    // Old line must stay on screen while the late commit is held off.
    for (int h = 0; h < 120; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL ovr_old_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    exp_ovr = 1'b1;
    checks++;
    if ({busy, overrun} !== {1'b1, exp_ovr}) begin
      failures++;
      $display("[TB] FAIL ovr_held got=%b exp=11", {busy, overrun});
    end
    video_on = 1'b0;
    wait_idle(cnt);
    commit_model(400);
    checks++;
    if (cnt >= 400) begin
      failures++;
      $display("[TB] FAIL ovr_timeout got=%0d exp=<400", cnt);
    end
    video_on = 1'b1;
    for (int h = 0; h < 640; h++) begin
      h_count = 10'(h);
      @(posedge clock); #1;
      checks++;
      if ({snake_pixel, head_pixel} !== {exp_snake(h), exp_head(h)}) begin
        failures++;
        $display("[TB] FAIL ovr_new_line h=%0d got=%b exp=%b", h,
                 {snake_pixel, head_pixel}, {exp_snake(h), exp_head(h)});
      end
    end
    video_on = 1'b0;
    checks++;
    if (overrun !== exp_ovr) begin
      failures++;
      $display("[TB] FAIL ovr_sticky got=%b exp=%b", overrun, exp_ovr);
    end
  endtask

  // Main sequence: model starts from the reset state (zero snapshot, blank line).
  initial begin
    reset       = 1'b1;
    pos_x       = '0;
    pos_y       = '0;
    length      = '0;
    frame_start = 1'b0;
    line_req    = 1'b0;
    line_y      = '0;
    h_count     = '0;
    video_on    = 1'b0;
    fill_bus(0, 0);
    blen = 0;
    snap_from_bus();
    dvalid  = 1'b0;
    dn      = 0;
    dty     = 0;
    exp_ovr = 1'b0;

    test_reset();
    test_head_only();
    test_no_hit();
    test_right_edge();
    test_clamp();
    test_random_lines();
    test_frame_start_mid_scan();
    test_abort();
    test_reset_mid_scan();
    test_overrun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
